// File: rtl/fetch_mem_arbiter.sv
// fetch_mem_arbiter: shares one fixed-latency unified memory between instruction fetch and data access.
// Define ARB_PERF_CNT_EN to build the IF-stall and conflict performance counters.
module fetch_mem_arbiter #(
  parameter int MEM_LAT = 2,
  parameter int STARVE_MAX = 4,
  parameter int IM_BASE = 2048,
  parameter int IM_LIMIT = 6144,
  parameter int DM_BASE = 6144,
  parameter int DM_LIMIT = 16384
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [63:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  output logic        if_trap,
  output logic        if_stall,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [63:0] dm_addr,
  input  logic [63:0] dm_wdata,
  output logic        dm_gnt,
  output logic        dm_rvalid,
  output logic [63:0] dm_rdata,
  output logic        dm_trap,
  output logic        mem_en,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  input  logic [63:0] mem_rdata,
  output logic [31:0] perf_if_stall_cycles,
  output logic [31:0] perf_conflicts
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  localparam int CW = $clog2(MEM_LAT + 1);
  localparam int SW = $clog2(STARVE_MAX + 1);
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [SW-1:0] starve;
  logic owner, we, bad, hi, pick_if, ok, arb, st;
  logic [63:0] sel_addr;
  assign if_stall = if_req & ~if_rvalid;
  assign arb = state == IDLE && (if_req || dm_req);
  assign pick_if = if_req & (~dm_req | starve == SW'(STARVE_MAX));
  assign sel_addr = pick_if ? if_addr : dm_addr;
  assign st = ~pick_if & dm_we;
  assign ok = pick_if
    ? (sel_addr >= 64'(IM_BASE) && sel_addr < 64'(IM_LIMIT) && sel_addr[1:0] == 2'b0)
    : (sel_addr >= 64'(DM_BASE) && sel_addr < 64'(DM_LIMIT) && sel_addr[2:0] == 3'b0);
  always_ff @(posedge clk) state <= reset ? IDLE : state_n;
  always_comb begin
    state_n = state;
    state_n = state == IDLE  ? (arb ? ISSUE : IDLE)
            : state == ISSUE ? (bad ? RESP : WAIT)
            : state == WAIT  ? (cnt == CW'(1) ? RESP : WAIT)
            : IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      {if_gnt, dm_gnt, if_rvalid, dm_rvalid, if_trap, dm_trap, mem_en, mem_we} <= '0;
      {owner, we, bad, hi} <= '0;
      mem_addr <= '0;
      mem_wdata <= '0;
      if_rdata <= '0;
      dm_rdata <= '0;
      cnt <= '0;
      starve <= '0;
    end else begin
      {if_gnt, dm_gnt, if_rvalid, dm_rvalid, if_trap, dm_trap, mem_en, mem_we} <= '0;
      mem_addr <= '0;
      mem_wdata <= '0;
      if (arb) begin
        owner <= ~pick_if;
        we <= st;
        bad <= ~ok;
        hi <= sel_addr[2];
        if_gnt <= pick_if;
        dm_gnt <= ~pick_if;
        mem_en <= ok;
        mem_we <= ok & st;
        mem_addr <= ok ? sel_addr : '0;
        mem_wdata <= ok & st ? dm_wdata : '0;
        // starvation only accrues while a fetch is actually waiting behind data
        starve <= (pick_if | ~if_req) ? '0 : starve == SW'(STARVE_MAX) ? starve : starve + 1'b1;
      end
      if (state == ISSUE) cnt <= CW'(MEM_LAT);
      if (state == WAIT) cnt <= cnt - 1'b1;
      if (state_n == RESP) begin
        if_rvalid <= ~owner;
        dm_rvalid <= owner;
        if_trap <= ~owner & bad;
        dm_trap <= owner & bad;
        if (~owner) if_rdata <= bad ? '0 : hi ? mem_rdata[63:32] : mem_rdata[31:0];
        else if (~bad & ~we) dm_rdata <= mem_rdata;
      end
    end
  end
`ifdef ARB_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_if_stall_cycles <= '0;
      perf_conflicts <= '0;
    end else begin
      perf_if_stall_cycles <= perf_if_stall_cycles + {31'b0, if_stall};
      perf_conflicts <= perf_conflicts + {31'b0, state == IDLE && if_req && dm_req};
    end
  end
`else
  assign perf_if_stall_cycles = '0;
  assign perf_conflicts = '0;
`endif
endmodule

// File: tb/tb_fetch_mem_arbiter.sv
// tb_fetch_mem_arbiter: directed scenarios checked every cycle against a transaction schedule model.
module tb_fetch_mem_arbiter;
  localparam int L = 2, SM = 4, N = 4096;
  logic clk = 0, reset = 1;
  logic if_req = 0, dm_req = 0, dm_we = 0;
  logic [63:0] if_addr = 0, dm_addr = 0, dm_wdata = 0, mem_rdata = 0;
  logic if_gnt, if_rvalid, if_trap, if_stall, dm_gnt, dm_rvalid, dm_trap, mem_en, mem_we;
  logic [31:0] if_rdata, perf_if_stall_cycles, perf_conflicts;
  logic [63:0] dm_rdata, mem_addr, mem_wdata;
  always #5 clk = ~clk;
  fetch_mem_arbiter #(.MEM_LAT(L), .STARVE_MAX(SM)) dut (
    .clk(clk), .reset(reset), .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_trap(if_trap), .if_stall(if_stall),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_gnt(dm_gnt),
    .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata), .dm_trap(dm_trap), .mem_en(mem_en),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .perf_if_stall_cycles(perf_if_stall_cycles), .perf_conflicts(perf_conflicts));
  int checks = 0, errors = 0, cyc = 0;
  bit started = 0;
  logic [63:0] mem [0:2047];
  bit e_if_gnt[N], e_dm_gnt[N], e_mem_en[N], e_mem_we[N], e_if_rv[N], e_dm_rv[N], e_if_trap[N], e_dm_trap[N];
  logic [63:0] e_mem_addr[N], e_mem_wdata[N];
  int free_at = 0, starve = 0, if_upd_at = -1, dm_upd_at = -1, rd_due = -1;
  logic [31:0] if_upd_val = 0, cur_if_rdata = 0, exp_stall = 0, exp_conf = 0;
  logic [63:0] dm_upd_val = 0, cur_dm_rdata = 0, rd_addr = 0;
  function automatic logic [63:0] pat(int i);
    return {32'hC0DE0000 | 32'(i), ~32'(i)};
  endfunction
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (cycle %0d): got %h, expected %h", name, cyc, act, exp);
    end
  endtask
  // Model: each arbitration schedules the whole transaction's visible events at absolute cycles.
  initial forever begin
    @(posedge clk);
    begin : model
      int n, r;
      bit pick_if, ok, st;
      logic [63:0] a, w;
      n = cyc;
      cyc = n + 1;
      if (reset) begin
        started = 1;
        for (int i = n + 1; i <= n + L + 4; i++) begin
          e_if_gnt[i] = 0; e_dm_gnt[i] = 0; e_mem_en[i] = 0; e_mem_we[i] = 0;
          e_if_rv[i] = 0; e_dm_rv[i] = 0; e_if_trap[i] = 0; e_dm_trap[i] = 0;
          e_mem_addr[i] = 0; e_mem_wdata[i] = 0;
        end
        free_at = n + 1; starve = 0; if_upd_at = -1; dm_upd_at = -1; rd_due = -1;
        cur_if_rdata = 0; cur_dm_rdata = 0; exp_stall = 0; exp_conf = 0;
      end else if (started) begin
        if (if_req && !e_if_rv[n]) exp_stall++;
        if (n >= free_at && (if_req || dm_req)) begin
          if (if_req && dm_req) exp_conf++;
          pick_if = if_req && (!dm_req || starve == SM);
          starve = (pick_if || !if_req) ? 0 : (starve < SM ? starve + 1 : SM);
          a = pick_if ? if_addr : dm_addr;
          st = !pick_if && dm_we;
          ok = pick_if ? (a >= 2048 && a < 6144 && a % 4 == 0) : (a >= 6144 && a < 16384 && a % 8 == 0);
          w = mem[a[13:3]];
          r = ok ? n + 2 + L : n + 2;
          if (pick_if) e_if_gnt[n+1] = 1; else e_dm_gnt[n+1] = 1;
          e_mem_en[n+1] = ok;
          e_mem_we[n+1] = ok && st;
          e_mem_addr[n+1] = a;
          e_mem_wdata[n+1] = (ok && st) ? dm_wdata : 64'h0;
          if (pick_if) begin
            e_if_rv[r] = 1; e_if_trap[r] = !ok; if_upd_at = r;
            if_upd_val = !ok ? 32'h0 : (a % 8 == 4 ? w[63:32] : w[31:0]);
          end else begin
            e_dm_rv[r] = 1; e_dm_trap[r] = !ok;
            if (ok && !st) begin dm_upd_at = r; dm_upd_val = w; end
          end
          free_at = r + 1;
        end
      end
      if (cyc == if_upd_at) cur_if_rdata = if_upd_val;
      if (cyc == dm_upd_at) cur_dm_rdata = dm_upd_val;
    end
  end
  initial forever begin
    @(posedge clk);
    #1 mem_rdata = (cyc == rd_due) ? mem[rd_addr[13:3]] : 64'hDEAD_BEEF_0BAD_F00D;
  end
  initial forever begin
    @(negedge clk);
    if (started) begin
      chk("if_gnt", if_gnt, e_if_gnt[cyc]);
      chk("dm_gnt", dm_gnt, e_dm_gnt[cyc]);
      chk("mem_en", mem_en, e_mem_en[cyc]);
      chk("mem_we", mem_we, e_mem_we[cyc]);
      chk("mem_wdata", mem_wdata, e_mem_wdata[cyc]);
      if (e_mem_en[cyc]) chk("mem_addr", mem_addr, e_mem_addr[cyc]);
      chk("if_rvalid", if_rvalid, e_if_rv[cyc]);
      chk("dm_rvalid", dm_rvalid, e_dm_rv[cyc]);
      if (e_if_rv[cyc]) chk("if_trap", if_trap, e_if_trap[cyc]);
      if (e_dm_rv[cyc]) chk("dm_trap", dm_trap, e_dm_trap[cyc]);
      chk("if_rdata", if_rdata, cur_if_rdata);
      chk("dm_rdata", dm_rdata, cur_dm_rdata);
      chk("if_stall", if_stall, if_req && !e_if_rv[cyc]);
`ifdef ARB_PERF_CNT_EN
      chk("perf_stall", perf_if_stall_cycles, exp_stall);
      chk("perf_conf", perf_conflicts, exp_conf);
`else
      chk("perf_stall", perf_if_stall_cycles, 0);
      chk("perf_conf", perf_conflicts, 0);
`endif
    end
    if (mem_en === 1'b1) begin
      if (mem_we) mem[mem_addr[13:3]] = mem_wdata;
      else begin rd_due = cyc + L; rd_addr = mem_addr; end
    end
  end
  logic s_if_gnt, s_dm_gnt, s_if_rv, s_dm_rv, s_mem_en, s_mem_we, s_if_trap, s_dm_trap;
  logic [63:0] s_mem_addr, s_mem_wdata, s_dm_rdata, r_mem_addr, r_mem_wdata, r_dm_rdata;
  logic [31:0] s_if_rdata, s_perf_stall, s_perf_conf, r_if_rdata, r_perf_stall, r_perf_conf;
  logic r_mem_en, r_mem_we, r_if_trap, r_dm_trap;
  int s_cyc, g_if_gnt, g_dm_gnt, g_if_rv, g_dm_rv, n_dm_pre, n_dm_post, n_mem_en;
  task automatic step();
    @(negedge clk);
    s_cyc = cyc; s_if_gnt = if_gnt; s_dm_gnt = dm_gnt; s_if_rv = if_rvalid; s_dm_rv = dm_rvalid;
    s_mem_en = mem_en; s_mem_we = mem_we; s_mem_addr = mem_addr; s_mem_wdata = mem_wdata;
    s_if_trap = if_trap; s_dm_trap = dm_trap; s_if_rdata = if_rdata; s_dm_rdata = dm_rdata;
    s_perf_stall = perf_if_stall_cycles; s_perf_conf = perf_conflicts;
    @(posedge clk);
    #1;
  endtask
  task automatic run(int n, bit hold);
    int t0;
    t0 = cyc;
    g_if_gnt = -1; g_dm_gnt = -1; g_if_rv = -1; g_dm_rv = -1;
    n_dm_pre = 0; n_dm_post = 0; n_mem_en = 0;
    for (int k = 0; k < n; k++) begin
      step();
      if (k == 0) begin r_perf_stall = s_perf_stall; r_perf_conf = s_perf_conf; end
      if (s_mem_en) n_mem_en++;
      if (s_dm_gnt) begin
        if (g_if_gnt < 0) n_dm_pre++; else n_dm_post++;
        if (g_dm_gnt < 0) begin g_dm_gnt = s_cyc - t0; r_mem_we = s_mem_we; r_mem_wdata = s_mem_wdata; end
      end
      if (s_if_gnt && g_if_gnt < 0) begin g_if_gnt = s_cyc - t0; r_mem_addr = s_mem_addr; r_mem_en = s_mem_en; end
      if (s_if_rv && g_if_rv < 0) begin g_if_rv = s_cyc - t0; r_if_rdata = s_if_rdata; r_if_trap = s_if_trap; end
      if (s_dm_rv && g_dm_rv < 0) begin g_dm_rv = s_cyc - t0; r_dm_rdata = s_dm_rdata; r_dm_trap = s_dm_trap; end
      if (s_if_rv) if_req = 0;
      if (s_dm_gnt && !hold) dm_req = 0;
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = pat(i);
    mem[256] = 64'h00A0_0513_0640_0093;
    mem[768] = 64'h1122_3344_5566_7788;
    repeat (3) @(posedge clk);
    #1 reset = 0;
    if_addr = 2048; if_req = 1;
    run(8, 0);
    chk("t1_if_gnt_cycle", g_if_gnt, 1);
    chk("t1_mem_addr", r_mem_addr, 2048);
    chk("t1_if_rvalid_cycle", g_if_rv, 4);
    chk("t1_if_rdata", r_if_rdata, 32'h0640_0093);
    if_addr = 2052; dm_addr = 6144; dm_we = 0; if_req = 1; dm_req = 1;
    run(12, 0);
    chk("t2_dm_gnt_cycle", g_dm_gnt, 1);
    chk("t2_dm_rvalid_cycle", g_dm_rv, 4);
    chk("t2_dm_rdata", r_dm_rdata, 64'h1122_3344_5566_7788);
    chk("t2_if_gnt_cycle", g_if_gnt, 6);
    chk("t2_if_rvalid_cycle", g_if_rv, 9);
    chk("t2_if_rdata", r_if_rdata, 32'h00A0_0513);
    if_addr = 2056; dm_addr = 6152; if_req = 1; dm_req = 1;
    run(33, 1);
    dm_req = 0;
    chk("t3_dm_before_if", n_dm_pre, 4);
    chk("t3_if_gnt_cycle", g_if_gnt, 21);
    chk("t3_dm_after_if", n_dm_post, 2);
    run(4, 0);
    if_addr = 1024; if_req = 1;
    run(6, 0);
    chk("t4_if_gnt_cycle", g_if_gnt, 1);
    chk("t4_if_rvalid_cycle", g_if_rv, 2);
    chk("t4_if_trap", r_if_trap, 1);
    chk("t4_if_rdata", r_if_rdata, 0);
    chk("t4_mem_en_count", n_mem_en, 0);
    dm_addr = 6148; dm_req = 1;
    run(6, 0);
    chk("t4_dm_misaligned_rv", g_dm_rv, 2);
    chk("t4_dm_misaligned_trap", r_dm_trap, 1);
    dm_addr = 16384; dm_req = 1;
    run(6, 0);
    chk("t4_dm_limit_trap", r_dm_trap, 1);
    chk("t4_dm_rdata_kept", r_dm_rdata, pat(769));
    dm_addr = 8192; dm_we = 1; dm_wdata = 64'h64; dm_req = 1;
    run(6, 0);
    chk("t5_store_mem_we", r_mem_we, 1);
    chk("t5_store_wdata", r_mem_wdata, 64'h64);
    chk("t5_store_rvalid_cycle", g_dm_rv, 4);
    chk("t5_store_trap", r_dm_trap, 0);
    chk("t5_store_rdata_kept", r_dm_rdata, pat(769));
    dm_we = 0; dm_wdata = 0; dm_req = 1;
    run(6, 0);
    chk("t5_load_back", r_dm_rdata, 64'h64);
    if_addr = 2048; if_req = 1;
    run(3, 0);
    reset = 1;
    run(1, 0);
    chk("t6_no_rvalid_in_reset", g_if_rv, -1);
    reset = 0;
    run(8, 0);
    chk("t6_perf_stall_cleared", r_perf_stall, 0);
    chk("t6_perf_conf_cleared", r_perf_conf, 0);
    chk("t6_if_gnt_cycle", g_if_gnt, 1);
    chk("t6_mem_en", r_mem_en, 1);
    chk("t6_if_rvalid_cycle", g_if_rv, 4);
    chk("t6_if_rdata", r_if_rdata, 32'h0640_0093);
    run(3, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
